// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared constants for the 2x2 systolic feeder: FSM encoding, schedule lengths
// and the lane positions of each element inside a packed 2x2 tile.
package systolic_feeder_2x2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StWaitDone,
        StOutput
    } feeder_state_e;

    localparam int unsigned FeedLen  = 3;
    localparam int unsigned DrainLen = 2;

    // Packed tiles are {X00, X01, X10, X11} with X00 in the top lane.
    localparam int unsigned Lane00 = 3;
    localparam int unsigned Lane01 = 2;
    localparam int unsigned Lane10 = 1;
    localparam int unsigned Lane11 = 0;

endpackage

// File: rtl/systolic_feeder_2x2.sv
// Feeds one 2x2 A/B tile pair into a systolic array with diagonal skew, waits for
// the array to finish and presents the captured result on a valid/ready port.
module systolic_feeder_2x2
    import systolic_feeder_2x2_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned FRAC_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH*4-1:0] in_a,
    input  logic [WIDTH*4-1:0] in_b,
    output logic               arr_rst_n,
    output logic               arr_en,
    output logic [WIDTH-1:0]   arr_north0,
    output logic [WIDTH-1:0]   arr_north1,
    output logic [WIDTH-1:0]   arr_west0,
    output logic [WIDTH-1:0]   arr_west2,
    input  logic               arr_done,
    input  logic [WIDTH*4-1:0] arr_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH*4-1:0] out_data
);

    if (FRAC_WIDTH >= WIDTH) begin : g_bad_frac
        $error("FRAC_WIDTH must be smaller than WIDTH");
    end

    feeder_state_e      state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [WIDTH*4-1:0] tile_a_q, tile_a_d;
    logic [WIDTH*4-1:0] tile_b_q, tile_b_d;
    logic [WIDTH*4-1:0] out_data_q, out_data_d;
    logic               in_ready_q, out_valid_q;
    logic               arr_rst_n_q, arr_rst_n_d;
    logic               arr_en_q, arr_en_d;
    logic [WIDTH-1:0]   north0_q, north0_d, north1_q, north1_d;
    logic [WIDTH-1:0]   west0_q, west0_d, west2_q, west2_d;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        tile_a_d   = tile_a_q;
        tile_b_d   = tile_b_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready_q) begin
                    tile_a_d = in_a;
                    tile_b_d = in_b;
                    state_d  = StClear;
                end
            end
            StClear: begin
                state_d = StFeed;
                phase_d = 2'd0;
            end
            StFeed: begin
                if (phase_q == 2'(FeedLen - 1)) begin
                    state_d = StDrain;
                    phase_d = 2'd0;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            StDrain: begin
                if (phase_q == 2'(DrainLen - 1)) begin
                    state_d = StWaitDone;
                end else begin
                    phase_d = phase_q + 2'd1;
                end
            end
            StWaitDone: begin
                if (arr_done) begin
                    out_data_d = arr_out;
                    state_d    = StOutput;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Array-facing outputs are decoded from the next state so the registered
    // values line up with the state register in the same cycle.
    always_comb begin
        arr_rst_n_d = (state_d != StClear);
        arr_en_d    = (state_d == StFeed) || (state_d == StDrain);
        north0_d    = '0;
        north1_d    = '0;
        west0_d     = '0;
        west2_d     = '0;
        if (state_d == StFeed) begin
            case (phase_d)
                2'd0: begin
                    west0_d  = tile_a_q[Lane00*WIDTH +: WIDTH];
                    north0_d = tile_b_q[Lane00*WIDTH +: WIDTH];
                end
                2'd1: begin
                    west0_d  = tile_a_q[Lane01*WIDTH +: WIDTH];
                    west2_d  = tile_a_q[Lane10*WIDTH +: WIDTH];
                    north0_d = tile_b_q[Lane10*WIDTH +: WIDTH];
                    north1_d = tile_b_q[Lane01*WIDTH +: WIDTH];
                end
                2'd2: begin
                    west2_d  = tile_a_q[Lane11*WIDTH +: WIDTH];
                    north1_d = tile_b_q[Lane11*WIDTH +: WIDTH];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            phase_q     <= 2'd0;
            tile_a_q    <= '0;
            tile_b_q    <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            arr_rst_n_q <= 1'b0;
            arr_en_q    <= 1'b0;
            north0_q    <= '0;
            north1_q    <= '0;
            west0_q     <= '0;
            west2_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tile_a_q    <= tile_a_d;
            tile_b_q    <= tile_b_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= (state_d == StIdle);
            out_valid_q <= (state_d == StOutput);
            arr_rst_n_q <= arr_rst_n_d;
            arr_en_q    <= arr_en_d;
            north0_q    <= north0_d;
            north1_q    <= north1_d;
            west0_q     <= west0_d;
            west2_q     <= west2_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign arr_rst_n  = arr_rst_n_q;
    assign arr_en     = arr_en_q;
    assign arr_north0 = north0_q;
    assign arr_north1 = north1_q;
    assign arr_west0  = west0_q;
    assign arr_west2  = west2_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 with a behavioural Q8.8 2x2
// output-stationary array attached to the array-facing ports.
module tb_systolic_feeder_2x2;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [4*W-1:0] in_a = '0;
    logic [4*W-1:0] in_b = '0;
    logic           arr_rst_n, arr_en;
    logic [W-1:0]   arr_north0, arr_north1, arr_west0, arr_west2;
    logic           arr_done;
    logic [4*W-1:0] arr_out;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [4*W-1:0] out_data;

    int errors = 0;
    int checks = 0;

    logic         done_force = 1'b0;
    logic [W-1:0] acc00, acc01, acc10, acc11;
    logic [W-1:0] a00_r, a10_r, b00_r, b01_r;
    int           en_cnt;

    localparam logic [4*W-1:0] TileA  = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    localparam logic [4*W-1:0] TileB  = {16'h0500, 16'h0600, 16'h0700, 16'h0800};
    localparam logic [4*W-1:0] TileC  = {16'h1300, 16'h1600, 16'h2B00, 16'h3200};
    localparam logic [4*W-1:0] TileId = {16'h0100, 16'h0000, 16'h0000, 16'h0100};

    always #5 clk = ~clk;

    systolic_feeder_2x2 #(.WIDTH(W), .FRAC_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .arr_rst_n (arr_rst_n),
        .arr_en    (arr_en),
        .arr_north0(arr_north0),
        .arr_north1(arr_north1),
        .arr_west0 (arr_west0),
        .arr_west2 (arr_west2),
        .arr_done  (arr_done),
        .arr_out   (arr_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic logic [W-1:0] qmul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [2*W-1:0] p;
        p = $signed(x) * $signed(y);
        return p[W+7:8];
    endfunction

    // Array model: PE(i,j) accumulates, operands shift east/south one cycle per PE.
    always @(posedge clk) begin
        if (!arr_rst_n) begin
            {acc00, acc01, acc10, acc11} <= '0;
            {a00_r, a10_r, b00_r, b01_r} <= '0;
            en_cnt <= 0;
        end else if (arr_en) begin
            acc00  <= acc00 + qmul(arr_west0, arr_north0);
            acc01  <= acc01 + qmul(a00_r, arr_north1);
            acc10  <= acc10 + qmul(arr_west2, b00_r);
            acc11  <= acc11 + qmul(a10_r, b01_r);
            a00_r  <= arr_west0;
            a10_r  <= arr_west2;
            b00_r  <= arr_north0;
            b01_r  <= arr_north1;
            en_cnt <= en_cnt + 1;
        end
    end

    assign arr_out  = {acc00, acc01, acc10, acc11};
    assign arr_done = done_force || (arr_rst_n && !arr_en && en_cnt == 5);

    // {in_ready, out_valid, arr_rst_n, arr_en, north0, north1, west0, west2} for cycle k
    function automatic logic [4*W+3:0] expect_cycle(input int k, input logic [4*W-1:0] a,
                                                    input logic [4*W-1:0] b);
        logic [W-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
        {a00, a01, a10, a11} = a;
        {b00, b01, b10, b11} = b;
        case (k)
            1:       return {4'b0000, {4*W{1'b0}}};
            2:       return {4'b0011, b00, 16'h0000, a00, 16'h0000};
            3:       return {4'b0011, b10, b01, a01, a10};
            4:       return {4'b0011, 16'h0000, b11, 16'h0000, a11};
            5, 6:    return {4'b0011, {4*W{1'b0}}};
            default: return {4'b0010, {4*W{1'b0}}};
        endcase
    endfunction

    task automatic accept(input logic [4*W-1:0] a, input logic [4*W-1:0] b);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_in_ready: got %b want 1", in_ready);
        end
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Accepts a tile, checks every array-facing cycle, ends at negedge of first OUTPUT cycle.
    task automatic run_tile(input logic [4*W-1:0] a, input logic [4*W-1:0] b,
                            input logic [4*W-1:0] c, input bit spurious);
        logic [4*W+3:0] obs, exp_v;
        accept(a, b);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            obs = {in_ready, out_valid, arr_rst_n, arr_en,
                   arr_north0, arr_north1, arr_west0, arr_west2};
            exp_v = expect_cycle(k, a, b);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL skew_cycle%0d: got %h want %h", k, obs, exp_v);
            end
            if (spurious) done_force = (k >= 2 && k <= 4);
        end
        checks++;
        if (en_cnt !== 5) begin
            errors++;
            $display("FAIL en_count: got %0d want 5", en_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== c) begin
            errors++;
            $display("FAIL result_latency7: got valid=%b data=%h want valid=1 data=%h",
                     out_valid, out_data, c);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: got valid=%b ready=%b want valid=0 ready=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        logic [4*W+3:0] obs;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {in_ready, out_valid, arr_rst_n, arr_en,
               arr_north0, arr_north1, arr_west0, arr_west2};
        checks++;
        if (obs !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h data=%h want all zero", obs, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || arr_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got ready=%b arr_rst_n=%b want 1 1", in_ready, arr_rst_n);
        end
    endtask

    task automatic test_single_tile();
        run_tile(TileA, TileB, TileC, 1'b0);
        release_result();
    endtask

    task automatic test_backpressure();
        logic ok = 1'b1;
        run_tile(TileB, TileId, TileB, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== TileB || in_ready !== 1'b0) begin
                errors++;
                ok = 1'b0;
                $display("FAIL backpressure_hold%0d: got valid=%b data=%h ready=%b want 1 %h 0",
                         i, out_valid, out_data, in_ready, TileB);
            end
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        run_tile(TileA, TileB, TileC, 1'b0);
        release_result();
        run_tile(TileId, TileB, TileB, 1'b0);
        release_result();
    endtask

    task automatic test_reset_mid();
        logic [4*W+3:0] obs;
        logic seen_valid = 1'b0;
        accept(TileA, TileB);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        obs = {in_ready, out_valid, arr_rst_n, arr_en,
               arr_north0, arr_north1, arr_west0, arr_west2};
        checks++;
        if (obs !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h data=%h want all zero", obs, out_data);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_no_valid: got seen_valid=%b ready=%b want 0 1",
                     seen_valid, in_ready);
        end
        run_tile(TileA, TileB, TileC, 1'b0);
        release_result();
    endtask

    task automatic test_spurious_done();
        done_force = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL spurious_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready);
            end
        end
        done_force = 1'b0;
        run_tile(TileId, TileB, TileB, 1'b1);
        done_force = 1'b0;
        release_result();
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_spurious_done();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_2x2.md
SYSTOLIC_FEEDER_2X2 -- requirements
Module: systolic_feeder_2x2

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the fixed-point word width shared with the 2x2 array.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8, passed through for consistency and not used arithmetically.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a tile pair is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: feeder accepts a tile pair.
REQ-007 SHALL have port in_a, input, WIDTH*4 bits: packed {A00,A01,A10,A11}, MSB first.
REQ-008 SHALL have port in_b, input, WIDTH*4 bits: packed {B00,B01,B10,B11}, MSB first.
REQ-009 SHALL have port arr_rst_n, output, 1 bit: array clear, active-low, synchronous.
REQ-010 SHALL have port arr_en, output, 1 bit: array enable.
REQ-011 SHALL have ports arr_north0, arr_north1, arr_west0, arr_west2, outputs, WIDTH bits each: skewed operands.
REQ-012 SHALL have port arr_done, input, 1 bit: array completion flag.
REQ-013 SHALL have port arr_out, input, WIDTH*4 bits: array results {C00,C01,C10,C11}.
REQ-014 SHALL have ports out_valid, output, 1 bit, and out_ready, input, 1 bit: result handshake.
REQ-015 SHALL have port out_data, output, WIDTH*4 bits: captured {C00,C01,C10,C11}.

Function
REQ-016 SHALL implement the FSM IDLE -> CLEAR -> FEED -> DRAIN -> WAIT_DONE -> OUTPUT -> IDLE.
REQ-017 SHALL hold in_ready = 1 only in IDLE; on in_valid && in_ready, SHALL latch in_a and in_b and enter CLEAR.
REQ-018 SHALL, in CLEAR (1 cycle), drive arr_rst_n = 0 and arr_en = 0 with all operands 0, then enter FEED.
REQ-019 SHALL, in FEED (3 cycles, f = 0..2), drive arr_en = 1 with the following operands:
- f0: west0 = A00, west2 = 0, north0 = B00, north1 = 0
- f1: west0 = A01, west2 = A10, north0 = B10, north1 = B01
- f2: west0 = 0, west2 = A11, north0 = 0, north1 = B11
REQ-020 SHALL, in DRAIN (2 cycles), drive arr_en = 1 with all operands 0, giving exactly 5 consecutive arr_en cycles per tile.
REQ-021 SHALL, in WAIT_DONE, drive arr_en = 0 and operands 0; on arr_done = 1, SHALL capture arr_out into out_data and enter OUTPUT.
REQ-022 SHALL, in OUTPUT, hold out_valid = 1 and out_data stable until out_ready = 1, then return to IDLE; at most one result outstanding.
REQ-023 SHALL ignore arr_done in every state other than WAIT_DONE.
REQ-024 SHALL drive all array-facing outputs from registers, aligned to the FSM state of the same cycle.
REQ-025 SHALL give minimum latency from input acceptance to out_valid of 1 CLEAR + 3 FEED + 2 DRAIN + 1 WAIT_DONE = 7 cycles, assuming arr_done asserts on the first WAIT_DONE cycle.
REQ-026 SHALL NOT perform arithmetic; operands pass bit-exact, and zero is all-zero bits.
REQ-027 SHALL keep a 2-bit phase counter that resets to 0 on entry to FEED and to DRAIN; it SHALL NOT wrap within a state.

Reset
REQ-028 SHALL, on rst_n = 0 at a clock edge, set state = IDLE, in_ready = 0 during reset (1 from the first cycle after reset), arr_rst_n = 0, arr_en = 0, all operands 0, out_valid = 0, out_data = 0.
REQ-029 SHALL, on reset mid-operation (any state), discard the tile and any pending result with no out_valid pulse.
REQ-030 SHALL drive arr_rst_n = 1 in all states except CLEAR and reset.

Structure
REQ-031 SHALL place the FSM state encoding, the FEED length (3), the DRAIN length (2) and the lane-index constants in the shared systolic package.
REQ-032 SHALL require no sub-module; the skew table is a case on the phase counter inside this module.

Verification
REQ-033 SHALL cover this single-tile case in Q8.8: A = {0x0100, 0x0200, 0x0300, 0x0400}, B = {0x0500, 0x0600, 0x0700, 0x0800} with the array instantiated -> out_data = {0x1300, 0x1600, 0x2B00, 0x3200}, out_valid 7 cycles after acceptance.
REQ-034 SHALL cover the skew check: a per-cycle monitor on the north/west ports matches the REQ-019 table exactly and counts 5 arr_en cycles per tile.
REQ-035 SHALL cover backpressure: out_ready held 0 for 10 cycles -> out_valid stays 1, out_data stable, in_ready stays 0.
REQ-036 SHALL cover back-to-back tiles: second tile identity A = {0x0100, 0, 0, 0x0100} with B as in REQ-033 -> out_data = B; arr_rst_n pulses before each FEED.
REQ-037 SHALL cover reset asserted at f1 -> next cycle all outputs 0, arr_en = 0, no out_valid; a subsequent tile completes correctly.
REQ-038 SHALL cover a spurious arr_done = 1 during IDLE and FEED -> ignored, with no early capture.
